// File: rtl/silife_pkg.sv
// Shared MAX7219 register addresses, FSM state type and frame word builder
// for the silife matrix-to-MAX7219 SPI driver.
package silife_pkg;

  localparam logic [3:0] ADDR_NOOP       = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;

  localparam logic [3:0] FIRST_ROW_WORD = 4'd4;
  localparam logic [3:0] LAST_WORD      = 4'd11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch,
    StDone
  } state_e;

  // Words 0..3 are the init sequence, 4..11 carry rows 0..7 with column 0 as data MSB.
  function automatic logic [15:0] frame_word(input logic [3:0] idx, input logic [7:0] cells,
                                             input logic [3:0] intensity);
    logic [7:0] rev;
    logic [3:0] addr;
    for (int c = 0; c < 8; c++) rev[7-c] = cells[c];
    addr = ADDR_DIGIT0 + (idx - FIRST_ROW_WORD);
    case (idx)
      4'd0:    frame_word = {ADDR_NOOP, ADDR_SHUTDOWN, 8'h01};
      4'd1:    frame_word = {ADDR_NOOP, ADDR_DECODE, 8'h00};
      4'd2:    frame_word = {ADDR_NOOP, ADDR_INTENSITY, 4'h0, intensity};
      4'd3:    frame_word = {ADDR_NOOP, ADDR_SCAN_LIMIT, 8'h07};
      default: frame_word = {ADDR_NOOP, addr, rev};
    endcase
  endfunction

endpackage

// File: rtl/silife_spi_shift.sv
// 16-bit MSB-first shift register with clock divider and bit counter;
// sequencing is controlled by the silife_max7219 FSM.
module silife_spi_shift
  import silife_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        shift,
  input  logic        div_clr,
  output logic        mosi,
  output logic        div_hit,
  output logic        bit_zero
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [15:0] sr_q;
  logic [3:0]  bit_q;
  logic [7:0]  div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      bit_q <= '0;
      div_q <= '0;
    end else if (load) begin
      sr_q  <= data;
      bit_q <= 4'd15;
      div_q <= '0;
    end else if (shift) begin
      sr_q  <= {sr_q[14:0], 1'b0};
      bit_q <= bit_q - 4'd1;
      div_q <= '0;
    end else if (div_clr) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign mosi     = sr_q[15];
  assign div_hit  = (div_q == DIV_LAST);
  assign bit_zero = (bit_q == 4'd0);

endmodule

// File: rtl/silife_max7219.sv
// Streams the 8x8 silife matrix to a MAX7219 over SPI mode 0, preceded by
// the init sequence on the first frame after reset.
module silife_max7219
  import silife_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] row_select,
  input  logic [7:0] cells,
  output logic       spi_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [3:0] idx_q;
  logic [3:0] idx_nxt;
  logic [2:0] row_nxt;
  logic       init_done_q;
  logic       cs_n_q, sclk_q, busy_q, done_q;
  logic [2:0] row_q;
  logic [15:0] word;
  logic       sh_load, sh_shift, sh_div_clr, div_hit, bit_zero;

  assign word       = frame_word(idx_q, cells, INTENSITY);
  assign sh_load    = (state_q == StLoad);
  assign sh_shift   = (state_q == StShiftHi) && div_hit && !bit_zero;
  assign sh_div_clr = div_hit || (state_q == StIdle) || (state_q == StDone);
  assign idx_nxt    = idx_q + 4'd1;
  assign row_nxt    = (idx_nxt >= FIRST_ROW_WORD) ? 3'(idx_nxt - FIRST_ROW_WORD) : 3'd0;

  silife_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .data     (word),
    .shift    (sh_shift),
    .div_clr  (sh_div_clr),
    .mosi     (spi_mosi),
    .div_hit  (div_hit),
    .bit_zero (bit_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            idx_q   <= init_done_q ? FIRST_ROW_WORD : 4'd0;
            row_q   <= '0;
          end
        end
        StLoad: state_q <= StShiftLo;
        StShiftLo: begin
          if (div_hit) begin
            state_q <= StShiftHi;
            sclk_q  <= 1'b1;
          end
        end
        StShiftHi: begin
          if (div_hit) begin
            sclk_q <= 1'b0;
            if (bit_zero) begin
              state_q <= StLatch;
              cs_n_q  <= 1'b1;
            end else begin
              state_q <= StShiftLo;
            end
          end
        end
        StLatch: begin
          if (div_hit) begin
            if (idx_q == LAST_WORD) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              row_q   <= '0;
            end else begin
              state_q <= StLoad;
              cs_n_q  <= 1'b0;
              idx_q   <= idx_nxt;
              row_q   <= row_nxt;
              if (idx_q == FIRST_ROW_WORD - 4'd1) init_done_q <= 1'b1;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign row_select = row_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_clk    = sclk_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_silife_max7219.sv
// Bench for silife_max7219: decodes SPI words from two instances (CLK_DIV 2 and 1)
// and compares them with a word-list model of the frame built from the matrix.
module tb_silife_max7219;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start[2] = '{1'b0, 1'b0};
  logic [2:0] row_sel[2];
  logic [7:0] cells[2];
  logic       cs_n[2], sclk[2], mosi[2], busy[2], done[2];

  silife_max7219 #(.CLK_DIV(2), .INTENSITY(4'h7)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .row_select(row_sel[0]), .cells(cells[0]),
    .spi_cs_n(cs_n[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .busy(busy[0]), .done(done[0])
  );

  silife_max7219 #(.CLK_DIV(1), .INTENSITY(4'hC)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .row_select(row_sel[1]), .cells(cells[1]),
    .spi_cs_n(cs_n[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .busy(busy[1]), .done(done[1])
  );

  int nchecks = 0;
  int npass   = 0;

  logic [7:0] mat[8];
  logic [7:0] noise[2];
  bit         noise_on = 1'b0;

  // Monitor state, written only by the monitor process
  int          cyc = 0;
  int          nwords[2] = '{0, 0};
  logic [15:0] wbuf[2][128];
  logic [2:0]  rbuf[2][128];
  logic [15:0] sh[2];
  int          bitcnt[2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          busy_cyc[2] = '{0, 0};
  int          viol[2] = '{0, 0};
  int          gap_err[2] = '{0, 0};
  int          last_rise[2] = '{0, 0};
  logic        cs_p[2] = '{1'b1, 1'b1};
  logic        sclk_p[2] = '{1'b0, 1'b0};
  logic        mosi_p[2] = '{1'b0, 1'b0};

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Matrix read port; noise replaces the row data once a word has started shifting
  always_comb begin
    for (int i = 0; i < 2; i++)
      cells[i] = (noise_on && bitcnt[i] != 0) ? noise[i] : mat[row_sel[i]];
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) done_cnt[i]++;
      if (busy[i]) busy_cyc[i]++;
      noise[i] = 8'($urandom);
      if (!cs_n[i] && cs_p[i]) bitcnt[i] = 0;
      if (!cs_n[i] && sclk[i] && !sclk_p[i]) begin
        if (bitcnt[i] > 0 && cyc - last_rise[i] != 2 * div_of(i)) gap_err[i]++;
        last_rise[i] = cyc;
        sh[i] = {sh[i][14:0], mosi[i]};
        bitcnt[i]++;
      end
      if (sclk[i] && mosi[i] !== mosi_p[i]) viol[i]++;
      if (cs_n[i] && !cs_p[i] && bitcnt[i] == 16 && nwords[i] < 128) begin
        wbuf[i][nwords[i]] = sh[i];
        rbuf[i][nwords[i]] = row_sel[i];
        nwords[i]++;
      end
      cs_p[i]   = cs_n[i];
      sclk_p[i] = sclk[i];
      mosi_p[i] = mosi[i];
    end
  end

  // Expected k-th word of a frame, straight from the MAX7219 command layout
  function automatic logic [15:0] model_word(input int k, input bit with_init,
                                             input logic [3:0] inten);
    logic [15:0] init_w[4];
    logic [7:0]  d;
    int r;
    init_w[0] = 16'h0C01;
    init_w[1] = 16'h0900;
    init_w[2] = 16'h0A00 | {12'h0, inten};
    init_w[3] = 16'h0B07;
    if (with_init && k < 4) return init_w[k];
    r = with_init ? k - 4 : k;
    d = 8'h00;
    for (int c = 0; c < 8; c++) if (mat[r][c]) d[7-c] = 1'b1;
    return 16'((r + 1) * 256 + int'(d));
  endfunction

  function automatic logic [2:0] model_row(input int k, input bit with_init);
    if (with_init && k < 4) return 3'd0;
    return 3'(with_init ? k - 4 : k);
  endfunction

  task automatic randomize_matrix();
    for (int r = 0; r < 8; r++) mat[r] = 8'($urandom);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int base);
    for (int n = 0; n < 3000 && done_cnt[i] == base; n++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      nchecks++; if (cs_n[i] !== 1'b1) $display("FAIL reset_cs_n[%0d]: got %b want 1", i, cs_n[i]); else npass++;
      nchecks++; if (sclk[i] !== 1'b0) $display("FAIL reset_spi_clk[%0d]: got %b want 0", i, sclk[i]); else npass++;
      nchecks++; if (mosi[i] !== 1'b0) $display("FAIL reset_mosi[%0d]: got %b want 0", i, mosi[i]); else npass++;
      nchecks++; if (row_sel[i] !== 3'd0) $display("FAIL reset_row[%0d]: got %0d want 0", i, row_sel[i]); else npass++;
      nchecks++; if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); else npass++;
      nchecks++; if (done[i] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); else npass++;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_init_frame();
    int base, dbase;
    logic [15:0] exp_w;
    randomize_matrix();
    base = nwords[0];
    dbase = done_cnt[0];
    pulse_start(0);
    wait_done(0, dbase);
    nchecks++; if (done_cnt[0] - dbase != 1) $display("FAIL init_done_count: got %0d want 1", done_cnt[0] - dbase); else npass++;
    nchecks++; if (nwords[0] - base != 12) $display("FAIL init_word_count: got %0d want 12", nwords[0] - base); else npass++;
    for (int k = 0; k < 12; k++) begin
      exp_w = model_word(k, 1'b1, 4'h7);
      nchecks++; if (wbuf[0][base+k] !== exp_w) $display("FAIL init_word[%0d]: got %h want %h", k, wbuf[0][base+k], exp_w); else npass++;
      nchecks++; if (rbuf[0][base+k] !== model_row(k, 1'b1)) $display("FAIL init_row[%0d]: got %0d want %0d", k, rbuf[0][base+k], model_row(k, 1'b1)); else npass++;
    end
  endtask

  task automatic test_blinker();
    int base, dbase, bbase;
    for (int r = 0; r < 8; r++) mat[r] = 8'h00;
    mat[4] = 8'h70;
    base = nwords[0];
    dbase = done_cnt[0];
    bbase = busy_cyc[0];
    pulse_start(0);
    wait_done(0, dbase);
    nchecks++; if (nwords[0] - base != 8) $display("FAIL blinker_word_count: got %0d want 8", nwords[0] - base); else npass++;
    nchecks++; if (wbuf[0][base+4] !== 16'h050E) $display("FAIL blinker_row4: got %h want 050e", wbuf[0][base+4]); else npass++;
    for (int k = 0; k < 8; k++) begin
      if (k != 4) begin
        nchecks++; if (wbuf[0][base+k] !== 16'((k + 1) * 256)) $display("FAIL blinker_word[%0d]: got %h want %h", k, wbuf[0][base+k], 16'((k + 1) * 256)); else npass++;
      end
    end
    nchecks++; if (busy_cyc[0] - bbase != 8 * (1 + 33 * 2)) $display("FAIL blinker_busy_cycles: got %0d want %0d", busy_cyc[0] - bbase, 8 * (1 + 33 * 2)); else npass++;
  endtask

  task automatic test_back_to_back();
    int base, dbase;
    logic [15:0] exp_w;
    randomize_matrix();
    base = nwords[0];
    dbase = done_cnt[0];
    pulse_start(0);
    repeat (100) @(posedge clk);
    pulse_start(0);
    repeat (300) @(posedge clk);
    pulse_start(0);
    wait_done(0, dbase);
    repeat (60) @(posedge clk);
    #1;
    nchecks++; if (done_cnt[0] - dbase != 1) $display("FAIL busy_start_done_count: got %0d want 1", done_cnt[0] - dbase); else npass++;
    nchecks++; if (nwords[0] - base != 8) $display("FAIL busy_start_word_count: got %0d want 8", nwords[0] - base); else npass++;
    for (int k = 0; k < 8; k++) begin
      exp_w = model_word(k, 1'b0, 4'h7);
      nchecks++; if (wbuf[0][base+k] !== exp_w) $display("FAIL busy_start_word[%0d]: got %h want %h", k, wbuf[0][base+k], exp_w); else npass++;
    end
  endtask

  task automatic test_cells_change();
    int base, dbase;
    logic [15:0] exp_w;
    randomize_matrix();
    base = nwords[0];
    dbase = done_cnt[0];
    noise_on = 1'b1;
    pulse_start(0);
    wait_done(0, dbase);
    noise_on = 1'b0;
    nchecks++; if (nwords[0] - base != 8) $display("FAIL noise_word_count: got %0d want 8", nwords[0] - base); else npass++;
    for (int k = 0; k < 8; k++) begin
      exp_w = model_word(k, 1'b0, 4'h7);
      nchecks++; if (wbuf[0][base+k] !== exp_w) $display("FAIL noise_word[%0d]: got %h want %h", k, wbuf[0][base+k], exp_w); else npass++;
    end
  endtask

  task automatic test_reset_mid();
    int base, dbase;
    logic [15:0] exp_w;
    randomize_matrix();
    base = nwords[0];
    pulse_start(0);
    // Row 3 is the fourth word of a non-init frame; bit 7 is the ninth bit shifted
    for (int n = 0; n < 3000 && !(nwords[0] == base + 3 && bitcnt[0] == 9); n++) begin
      @(posedge clk); #1;
    end
    nchecks++; if (!(nwords[0] == base + 3 && bitcnt[0] == 9)) $display("FAIL midreset_reach_bit7: got words=%0d bits=%0d want words=%0d bits=9", nwords[0] - base, bitcnt[0], 3); else npass++;
    nchecks++; if (sclk[0] !== 1'b1) $display("FAIL midreset_in_high_phase: got spi_clk=%b want 1", sclk[0]); else npass++;
    reset = 1'b1;
    @(posedge clk); #1;
    nchecks++; if (cs_n[0] !== 1'b1) $display("FAIL midreset_cs_n: got %b want 1", cs_n[0]); else npass++;
    nchecks++; if (sclk[0] !== 1'b0) $display("FAIL midreset_spi_clk: got %b want 0", sclk[0]); else npass++;
    nchecks++; if (busy[0] !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy[0]); else npass++;
    nchecks++; if (row_sel[0] !== 3'd0) $display("FAIL midreset_row: got %0d want 0", row_sel[0]); else npass++;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchecks++; if (nwords[0] - base != 3) $display("FAIL midreset_partial_word: got %0d words want 3", nwords[0] - base); else npass++;
    randomize_matrix();
    base = nwords[0];
    dbase = done_cnt[0];
    pulse_start(0);
    wait_done(0, dbase);
    nchecks++; if (nwords[0] - base != 12) $display("FAIL midreset_reinit_count: got %0d want 12", nwords[0] - base); else npass++;
    for (int k = 0; k < 12; k++) begin
      exp_w = model_word(k, 1'b1, 4'h7);
      nchecks++; if (wbuf[0][base+k] !== exp_w) $display("FAIL midreset_word[%0d]: got %h want %h", k, wbuf[0][base+k], exp_w); else npass++;
    end
  endtask

  task automatic test_div1();
    int base, dbase, bbase;
    logic [15:0] exp_w;
    randomize_matrix();
    base = nwords[1];
    dbase = done_cnt[1];
    bbase = busy_cyc[1];
    pulse_start(1);
    wait_done(1, dbase);
    nchecks++; if (done_cnt[1] - dbase != 1) $display("FAIL div1_done_count: got %0d want 1", done_cnt[1] - dbase); else npass++;
    nchecks++; if (nwords[1] - base != 12) $display("FAIL div1_word_count: got %0d want 12", nwords[1] - base); else npass++;
    for (int k = 0; k < 12; k++) begin
      exp_w = model_word(k, 1'b1, 4'hC);
      nchecks++; if (wbuf[1][base+k] !== exp_w) $display("FAIL div1_word[%0d]: got %h want %h", k, wbuf[1][base+k], exp_w); else npass++;
    end
    nchecks++; if (busy_cyc[1] - bbase != 12 * (1 + 33)) $display("FAIL div1_busy_cycles: got %0d want %0d", busy_cyc[1] - bbase, 12 * (1 + 33)); else npass++;
    for (int i = 0; i < 2; i++) begin
      nchecks++; if (gap_err[i] != 0) $display("FAIL spi_clk_period[%0d]: got %0d bad periods want 0", i, gap_err[i]); else npass++;
      nchecks++; if (viol[i] != 0) $display("FAIL mosi_stable[%0d]: got %0d changes while high want 0", i, viol[i]); else npass++;
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mat[r] = 8'h00;
    test_reset();
    test_init_frame();
    test_blinker();
    test_back_to_back();
    test_cells_change();
    test_reset_mid();
    test_div1();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
